// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tone_sequencer
// Description : Plays a programmed table of square-wave tones on one output.
//               Each table entry holds a half-period (hp) and a duration
//               (dur). An entry lasts 2*(hp+1)*(dur+1) cycles, and q toggles
//               every hp+1 cycles. An entry with hp=0 is a rest: its timing
//               is unchanged, but q is held low.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               wr_en/wr_addr/wr_hp/wr_dur - table write port (any state)
//               last_idx            - final entry index, latched on start
//               start, stop         - begin / abort the sequence
//               q                   - registered square-wave output
//               busy, done, cur_idx - playback status
// Options     : TONE_SEQUENCER_LOOP_EN adds input 'loop'. When loop is high
//               at the end of the last entry, playback wraps to entry 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
  parameter int HP_W   = 8,
  parameter int DUR_W  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [HP_W-1:0]   wr_hp,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              start,
  input  logic              stop,
`ifdef TONE_SEQUENCER_LOOP_EN
  input  logic              loop,
`endif
  output logic              q,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  // Tone table
  logic [HP_W-1:0]   hp_tbl_q  [DEPTH];
  logic [DUR_W-1:0]  dur_tbl_q [DEPTH];

  // Playback state and working copy of the current entry
  state_e            state_q;
  logic [ADDR_W-1:0] cur_idx_q;
  logic [ADDR_W-1:0] last_q;
  logic [HP_W-1:0]   hp_q;
  logic [DUR_W-1:0]  dur_q;
  logic [HP_W-1:0]   cnt_q;
  logic [DUR_W-1:0]  per_q;
  logic              tog_q;   // unmasked toggle; q is this gated by hp!=0
  logic              q_q;
  logic              busy_q;
  logic              done_q;

  logic              cnt_hit;
  logic              entry_end;
  logic              last_entry;
  logic [ADDR_W-1:0] idx_next_d;

  assign cnt_hit    = (cnt_q == hp_q);
  // An entry ends on its final falling toggle.
  assign entry_end  = cnt_hit && tog_q && (per_q == dur_q);
  assign last_entry = (cur_idx_q == last_q);
  assign idx_next_d = cur_idx_q + ADDR_W'(1);

  // Table writes. Loads read the pre-edge contents, so a same-edge write
  // and load of one address yields the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hp_tbl_q[i]  <= '0;
        dur_tbl_q[i] <= '0;
      end
    end else if (wr_en) begin
      hp_tbl_q[wr_addr]  <= wr_hp;
      dur_tbl_q[wr_addr] <= wr_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_idx_q <= '0;
      last_q    <= '0;
      hp_q      <= '0;
      dur_q     <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      tog_q     <= 1'b0;
      q_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q   <= S_PLAY;
            busy_q    <= 1'b1;
            cur_idx_q <= '0;
            last_q    <= last_idx;
            hp_q      <= hp_tbl_q[{ADDR_W{1'b0}}];
            dur_q     <= dur_tbl_q[{ADDR_W{1'b0}}];
            cnt_q     <= '0;
            per_q     <= '0;
            tog_q     <= 1'b0;
            q_q       <= 1'b0;
          end
        end
        S_PLAY: begin
          if (stop) begin
            // Abort takes priority over an entry end in the same cycle.
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cur_idx_q <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            tog_q     <= 1'b0;
            q_q       <= 1'b0;
          end else if (entry_end) begin
            cnt_q <= '0;
            per_q <= '0;
            tog_q <= 1'b0;
            q_q   <= 1'b0;
            if (!last_entry) begin
              cur_idx_q <= idx_next_d;
              hp_q      <= hp_tbl_q[idx_next_d];
              dur_q     <= dur_tbl_q[idx_next_d];
            end
`ifdef TONE_SEQUENCER_LOOP_EN
            else if (loop) begin
              cur_idx_q <= '0;
              hp_q      <= hp_tbl_q[{ADDR_W{1'b0}}];
              dur_q     <= dur_tbl_q[{ADDR_W{1'b0}}];
            end
`endif
            else begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              cur_idx_q <= '0;
            end
          end else if (cnt_hit) begin
            cnt_q <= '0;
            tog_q <= ~tog_q;
            // A rest keeps its timing but never drives q high.
            q_q   <= ~tog_q & (hp_q != '0);
            if (tog_q) begin
              per_q <= per_q + DUR_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + HP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = cur_idx_q;

endmodule
`default_nettype wire
